async_fifo_rd_ctrl: RTL
=======================

ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: memory address bits; depth = 2**ADDR_W.
REQ-003 SHALL have parameter AE_THRESH, default 1: almost_empty threshold in words.
REQ-004 SHALL have port rd_clk  in  1  sole clock; all state is on its rising edge.
REQ-005 SHALL have port rd_rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port wr_ptr_gray  in  ADDR_W+1  Gray-coded write pointer from the write clock domain, asynchronous to rd_clk.
REQ-007 SHALL have port rd_ptr_gray  out  ADDR_W+1  registered Gray-coded read pointer, sent to the write domain.
REQ-008 SHALL have port mem_rd_en  out  1  memory read strobe.
REQ-009 SHALL have port mem_rd_addr  out  ADDR_W  memory read address.
REQ-010 SHALL have port mem_rd_data  in  WIDTH  memory read data, valid the cycle after mem_rd_en is sampled.
REQ-011 SHALL have port m_data  out  WIDTH  output stream data.
REQ-012 SHALL have port m_valid  out  1  output stream valid.
REQ-013 SHALL have port m_ready  in  1  output stream ready.
REQ-014 SHALL have port empty  out  1  no word is held anywhere in the read path.
REQ-015 SHALL have port almost_empty  out  1  rd_level <= AE_THRESH.
REQ-016 SHALL have port rd_level  out  ADDR_W+1  memory-side word count, 0..2**ADDR_W.

Function
REQ-017 SHALL synchronise wr_ptr_gray through exactly two rd_clk flops (wq1, wq2) before any use; no logic between the flops.
REQ-018 SHALL hold the binary read pointer rbin (ADDR_W+1 bits) and drive rd_ptr_gray = rbin ^ (rbin>>1) from a register.
REQ-019 SHALL define mem_empty = (rd_ptr_gray == wq2).
REQ-020 SHALL compute rd_level = gray2bin(wq2) - rbin modulo 2**(ADDR_W+1), registered.
REQ-021 SHALL hold a 2-entry output buffer with occupancy occ (0..2) and a one-bit inflight flag for an outstanding memory read.
REQ-022 SHALL define pop = m_valid & m_ready.
REQ-023 SHALL drive mem_rd_en = !mem_empty & (occ + inflight - pop < 2), combinationally.
REQ-024 SHALL drive mem_rd_addr = rbin[ADDR_W-1:0].
REQ-025 SHALL, on each cycle with mem_rd_en=1, increment rbin by 1 (wrapping modulo 2**(ADDR_W+1)) and set inflight next cycle; otherwise clear inflight.
REQ-026 SHALL capture mem_rd_data into the buffer tail when inflight=1; a capture and a pop in the same cycle leave occ unchanged.
REQ-027 SHALL present the buffer head on m_data with m_valid = (occ != 0); m_data/m_valid SHALL stay stable while m_valid=1 & m_ready=0.
REQ-028 SHALL sustain one word per cycle when m_ready=1 and mem_empty=0.
REQ-029 SHALL drive empty = (occ == 0) & !inflight & mem_empty.
REQ-030 SHALL drive latency: a wr_ptr_gray change before edge E0 gives mem_rd_en=1 after E1, data capture at E3, and m_valid=1 after E3 (output buffer initially empty, m_ready don't-care).
REQ-031 SHALL never issue a read when mem_empty=1, regardless of m_ready.
REQ-032 SHALL keep wq2 transitions of more than one Gray step per cycle functionally correct: rd_level jumps by the full difference.

Reset
REQ-033 SHALL, while rd_rst=1, hold rbin, rd_ptr_gray, wq1, wq2, occ, inflight, rd_level and m_data at 0, with m_valid=0, mem_rd_en=0, empty=1 and almost_empty=1.
REQ-034 SHALL, on assertion of rd_rst mid-stream, discard buffered and in-flight words immediately, without waiting for an rd_clk edge.
REQ-035 SHALL resume operation on the first rd_clk edge after rd_rst deasserts.

Verification
REQ-036 Reset, then set wr_ptr_gray = 0001 (ADDR_W=3) with m_ready=1 -> mem_rd_en pulses once with addr 0 after E1; m_valid=1 for one cycle after E3; then empty=1 and rd_ptr_gray=0001.
REQ-037 Write 8 words (wr_ptr_gray = gray(8)=1100) with m_ready=0 -> rd_level reads 8 and drops to 6; occ=2; m_valid held; mem_rd_en=0.
REQ-038 From full, set m_ready=1 -> 8 words out on consecutive cycles, in addresses 0..7; then rd_level=0 and empty=1.
REQ-039 Stream 20 words, wrapping rbin past 15 -> 0, with random m_ready -> data matches in order; no read while mem_empty=1.
REQ-040 Assert rd_rst with occ=2 and inflight=1 -> m_valid=0 and rd_ptr_gray=0 without any rd_clk edge; with wr_ptr_gray=0, no output after release.
REQ-041 Set AE_THRESH=1 and rd_level 2->1->0 -> almost_empty=0, 1, 1.

Source files
------------

// File: rtl/async_fifo_rd_ctrl.sv
// async_fifo_rd_ctrl
//   Read-side controller of an asynchronous FIFO. It brings the Gray-coded
//   write pointer into rd_clk, issues reads to a synchronous memory with a
//   one-cycle read latency, and buffers the returned words in a two-entry
//   skid buffer. This keeps the output stream at one word per cycle while
//   still honouring m_ready backpressure.
//
// Ports
//   rd_clk        read-domain clock (all state on rising edge)
//   rd_rst        asynchronous active-high reset
//   wr_ptr_gray   Gray write pointer from the write domain (asynchronous)
//   rd_ptr_gray   registered Gray read pointer back to the write domain
//   mem_rd_en     memory read strobe
//   mem_rd_addr   memory read address
//   mem_rd_data   memory read data, valid the cycle after mem_rd_en is sampled
//   m_data        output stream data (head of skid buffer)
//   m_valid       output stream valid
//   m_ready       output stream ready
//   empty         no word in memory, in flight or buffered
//   almost_empty  rd_level <= AE_THRESH
//   rd_level      words still in memory as seen from the read domain
module async_fifo_rd_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]    r_wq1;
  logic [PW-1:0]    r_wq2;
  logic [PW-1:0]    r_rbin;
  logic [PW-1:0]    r_rptr_gray;
  logic [PW-1:0]    r_level;
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;

  logic             w_mem_empty;
  logic             w_pop;
  logic [2:0]       w_demand;
  logic [PW-1:0]    w_rbin_nxt;
  logic             w_tail_is_1;

  assign w_mem_empty = (r_rptr_gray == r_wq2);
  assign w_pop       = m_valid & m_ready;

  // Words that will be held (buffered + in flight) after this edge if no new
  // read is issued; a read is allowed only while that leaves room for it.
  assign w_demand    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign mem_rd_en   = !w_mem_empty && (w_demand < 3'd2);
  assign w_rbin_nxt  = r_rbin + {{ADDR_W{1'b0}}, mem_rd_en};

  // Slot the returning word lands in, after any pop this cycle shifts the head.
  assign w_tail_is_1 = (r_occ == 2'd2) || ((r_occ == 2'd1) && !w_pop);

  assign rd_ptr_gray  = r_rptr_gray;
  assign mem_rd_addr  = r_rbin[ADDR_W-1:0];
  assign m_data       = r_buf0;
  assign m_valid      = (r_occ != 2'd0);
  assign empty        = (r_occ == 2'd0) && !r_inflight && w_mem_empty;
  assign rd_level     = r_level;
  assign almost_empty = (r_level <= AE_T);

  // Stage 0: two-flop synchroniser for the write pointer, no logic between.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= wr_ptr_gray;
      r_wq2 <= r_wq1;
    end
  end

  // Stage 1: read pointer and level. The level is computed from the values
  // wq2 and rbin take at this edge, so it always matches the live pointers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_rbin      <= '0;
      r_rptr_gray <= '0;
      r_level     <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_rbin      <= w_rbin_nxt;
      r_rptr_gray <= bin2gray(w_rbin_nxt);
      r_level     <= gray2bin(r_wq1) - w_rbin_nxt;
      r_inflight  <= mem_rd_en;
    end
  end

  // Stage 2: skid buffer, head in buf0.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_inflight) begin
        if (w_tail_is_1) begin
          r_buf1 <= mem_rd_data;
        end else begin
          r_buf0 <= mem_rd_data;
        end
      end
    end
  end

endmodule
